switch_map_arbiter: RTL and testbench
=====================================

# switch_map_arbiter

Shares one piecewise code-mapping unit between two requesters. Each requester presents a 4-bit code with a valid/ready handshake. The arbiter grants one requester at a time by round-robin, evaluates the mapping in a registered pipeline and returns a 3-bit result tagged with the requester ID, holding it until the consumer accepts it. It sits between the code-producing front ends and the shared result sink, and counts completed transactions per requester.

## Interface
- No parameters; requester count (2), code width (4), result width (3) and counter width (8) are fixed.
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has a code pending
- req0_code  input  4  requester 0 code; must stay stable while req0_valid=1 and req0_ready=0
- req0_ready  output  1  requester 0 code accepted this cycle
- req1_valid  input  1  requester 1 has a code pending
- req1_code  input  4  requester 1 code; same stability rule
- req1_ready  output  1  requester 1 code accepted this cycle
- resp_valid  output  1  result available
- resp_id  output  1  requester that owns the result
- resp_val  output  3  mapped result
- resp_ready  input  1  consumer accepts the result
- busy  output  1  a transaction is in flight (state != IDLE)
- cnt0  output  8  completed responses for requester 0
- cnt1  output  8  completed responses for requester 1

## Operation
- Mapping f(c) on 4-bit unsigned c:
  - c<=3: (2c+7) mod 6
  - 4<=c<=10: (3c+2) mod 8
  - 11<=c<=15: c/3, truncated
- Compute f(c) with at least 6-bit intermediates. No overflow is permitted before the mod.
- Reference values for c=0..15: 1,3,5,1,6,1,4,7,2,5,0,3,4,4,4,5.
- FSM states:
  - IDLE: accepts a request.
  - EVAL: the latched code is mapped and the result registered.
  - RESP: the result is presented.
- Transitions:
  - IDLE→EVAL when any reqK_valid=1.
  - EVAL→RESP unconditionally.
  - RESP→IDLE when resp_ready=1.
- Arbitration, evaluated in IDLE only:
  - If one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - last_grant updates on every accept.
- reqK_ready = (state==IDLE) && (K is the winner). It is combinational from state, valids and last_grant. At most one ready is high per cycle.
- On accept: latch the code and the ID. The requester may change its code or drop valid on the next cycle.
- The result is computed from the latched code only. Input changes after accept have no effect.
- resp_id, resp_val and resp_valid are registered and held stable throughout RESP until the handshake.
- cntK increments by 1 on the response handshake (resp_valid && resp_ready) where resp_id=K. It wraps 255→0.

## Timing
- Reset values while rst_n=0 at a clock edge:
  - state=IDLE
  - resp_valid=0, resp_id=0, resp_val=0
  - busy=0, cnt0=0, cnt1=0
  - last_grant=1, so requester 0 wins the first tie
  - req0_ready and req1_ready are 0 during reset cycles
- Latency:
  - Accept at edge N.
  - EVAL during cycle N+1.
  - resp_valid=1 from edge N+2.
- Response handshake at edge M: resp_valid=0 from M+1. The earliest next accept is at M+1, with ready high in cycle M+1.
- Peak throughput: one transaction per 3 cycles.
- resp_ready high on the first RESP cycle completes the transaction in that cycle.
- resp_ready is ignored outside RESP.
- Backpressure: with resp_ready low, RESP holds indefinitely. Both readys stay 0 and outputs do not change.
- A request arriving in EVAL or RESP waits. It is considered at the next IDLE cycle with the round-robin state as of then.
- Reset mid-transaction (EVAL or RESP) discards the transaction:
  - No response is issued.
  - Counters clear.
  - The next accept uses last_grant=1.
- Simultaneous response handshake and new valid requests: the handshake completes first. The new request is accepted in the following IDLE cycle.

## Test plan
- Single request: req0 code 7 accepted at edge N → resp_valid at N+2 with resp_id=0, resp_val=7. With resp_ready=1, cnt0=1 after the handshake.
- Alternation: both valids held high, req0 code 2, req1 code 10, resp_ready=1 → responses in order (id0,5), (id1,0), (id0,5), (id1,0), one every 3 cycles.
- Backpressure: resp_ready low for 5 cycles during RESP with req1 valid → resp_val, resp_id and resp_valid are stable and both readys stay 0. After resp_ready rises, req1 is accepted the cycle after the handshake.
- Full sweep: req1 drives codes 0..15 one at a time → resp_val sequence 1,3,5,1,6,1,4,7,2,5,0,3,4,4,4,5 and cnt1=16.
- Reset mid-operation: rst_n low during EVAL of code 7 → no response, all outputs at reset values. First tie afterwards is granted to requester 0.
- Counter wrap: 257 completed req0 transactions → cnt0=1 and cnt1=0.

Source files
------------

// File: rtl/switch_map_arbiter.sv
// Two-requester round-robin arbiter sharing one registered code-mapping stage.
// Results are held until the consumer accepts them; completed responses are counted per requester.
module switch_map_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_code,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_code,
    output logic       req1_ready,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [2:0] resp_val,
    input  logic       resp_ready,
    output logic       busy,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);
    // state | meaning
    // IDLE  | waiting for a request; arbitration active
    // EVAL  | latched code is being mapped, result registered at end of cycle
    // RESP  | result presented until resp_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] code_q, code_d;
    logic       id_q, id_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_id_q, resp_id_d;
    logic [2:0] resp_val_q, resp_val_d;
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    logic win_valid;
    logic win_id;
    logic accept;

    // 6-bit intermediates keep 3c+2 (max 32) and 2c+7 exact before the modulo.
    function automatic logic [2:0] map_code(input logic [3:0] c);
        logic [5:0] w;
        logic [5:0] r;
        w = {2'b00, c};
        if (w <= 6'd3)
            r = (w + w + 6'd7) % 6'd6;
        else if (w <= 6'd10)
            r = (w + w + w + 6'd2) % 6'd8;
        else
            r = w / 6'd3;
        return 3'(r);
    endfunction

    always_comb begin
        win_valid  = req0_valid | req1_valid;
        win_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept     = rst_n && (state_q == S_IDLE) && win_valid;
        req0_ready = accept && !win_id;
        req1_ready = accept && win_id;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        code_d       = code_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_val_d   = resp_val_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    code_d       = win_id ? req1_code : req0_code;
                    id_d         = win_id;
                    last_grant_d = win_id;
                    state_d      = S_EVAL;
                end
            end
            S_EVAL: begin
                resp_val_d   = map_code(code_q);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (resp_id_q)
                        cnt1_d = cnt1_q + 8'd1;
                    else
                        cnt0_d = cnt0_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            code_q       <= 4'd0;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_val_q   <= 3'd0;
            cnt0_q       <= 8'd0;
            cnt1_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            code_q       <= code_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_val_q   <= resp_val_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_val   = resp_val_q;
    assign busy       = (state_q != S_IDLE);
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;
endmodule

// File: tb/tb_switch_map_arbiter.sv
// Bench for switch_map_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-phase reference model.
module tb_switch_map_arbiter;
    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_code, req1_code;
    logic       req0_ready, req1_ready;
    logic       resp_valid, resp_id;
    logic [2:0] resp_val;
    logic       resp_ready;
    logic       busy;
    logic [7:0] cnt0, cnt1;

    switch_map_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_val(resp_val),
        .resp_ready(resp_ready), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: phase 0 waiting, 1 mapping, 2 presenting
    int m_phase = 0, m_last = 1, m_lid = 0, m_lcode = 0;
    int m_rid = 0, m_rval = 0, m_cnt0 = 0, m_cnt1 = 0;

    bit acc0, acc1, hs;
    int hs_id, hs_val;

    int ref_tab [16] = '{1, 3, 5, 1, 6, 1, 4, 7, 2, 5, 0, 3, 4, 4, 4, 5};

    function automatic int f_ref(input int c);
        if (c <= 3) return (2 * c + 7) % 6;
        else if (c <= 10) return (3 * c + 2) % 8;
        else return c / 3;
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit v0, input logic [3:0] c0,
                        input bit v1, input logic [3:0] c1, input bit rr);
        int e0, e1;
        @(negedge clk);
        rst_n = rn; req0_valid = v0; req0_code = c0;
        req1_valid = v1; req1_code = c1; resp_ready = rr;
        #1;
        e0 = 0; e1 = 0;
        if (rn && m_phase == 0) begin
            if (v0 && v1) begin
                if (m_last == 1) e0 = 1; else e1 = 1;
            end else begin
                e0 = int'(v0); e1 = int'(v1);
            end
        end
        chk("req0_ready", int'(req0_ready), e0);
        chk("req1_ready", int'(req1_ready), e1);
        acc0 = req0_ready; acc1 = req1_ready;
        hs = resp_valid && rr; hs_id = int'(resp_id); hs_val = int'(resp_val);
        @(posedge clk);
        if (!rn) begin
            m_phase = 0; m_last = 1; m_rid = 0; m_rval = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_phase == 0) begin
            if (e0 != 0 || e1 != 0) begin
                m_lid = (e1 != 0) ? 1 : 0;
                m_lcode = (e1 != 0) ? int'(c1) : int'(c0);
                m_last = m_lid;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_rid = m_lid; m_rval = f_ref(m_lcode); m_phase = 2;
        end else if (rr) begin
            if (m_rid == 0) m_cnt0 = (m_cnt0 + 1) % 256;
            else m_cnt1 = (m_cnt1 + 1) % 256;
            m_phase = 0;
        end
        #1;
        chk("resp_valid", int'(resp_valid), (m_phase == 2) ? 1 : 0);
        chk("resp_id", int'(resp_id), m_rid);
        chk("resp_val", int'(resp_val), m_rval);
        chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
        chk("cnt0", int'(cnt0), m_cnt0);
        chk("cnt1", int'(cnt1), m_cnt1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) step(0, 1, 4'd5, 1, 4'd6, 1);
    endtask

    initial begin
        int hs_ids[$];
        int hs_vals[$];
        int hs_at[$];
        int held_val, held_id;
        bit v0, v1;
        logic [3:0] c0, c1;

        rst_n = 0; req0_valid = 0; req1_valid = 0;
        req0_code = 0; req1_code = 0; resp_ready = 0;

        // reset state
        do_reset();
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);

        // single request, code 7
        step(1, 1, 4'd7, 0, 4'd0, 1);
        chk("single_accept", int'(acc0), 1);
        step(1, 0, 4'd0, 0, 4'd0, 1);
        chk("single_not_yet", int'(resp_valid), 1);
        step(1, 0, 4'd0, 0, 4'd0, 1);
        chk("single_hs", int'(hs), 1);
        chk("single_val", hs_val, 7);
        chk("single_id", hs_id, 0);
        chk("single_cnt0", int'(cnt0), 1);

        // alternation under permanent tie
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 4'd2, 1, 4'd10, 1);
            if (hs) begin hs_ids.push_back(hs_id); hs_vals.push_back(hs_val); hs_at.push_back(i); end
        end
        chk("alt_count", hs_ids.size(), 4);
        if (hs_ids.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("alt_id", hs_ids[i], i % 2);
                chk("alt_val", hs_vals[i], (i % 2 == 0) ? 5 : 0);
                chk("alt_time", hs_at[i], 2 + 3 * i);
            end
        end

        // backpressure with req1 waiting
        do_reset();
        step(1, 1, 4'd3, 0, 4'd0, 0);
        step(1, 0, 4'd0, 1, 4'd9, 0);
        held_val = int'(resp_val); held_id = int'(resp_id);
        chk("bp_val_first", held_val, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 4'd0, 1, 4'd9, 0);
            chk("bp_hold_val", int'(resp_val), held_val);
            chk("bp_hold_id", int'(resp_id), held_id);
            chk("bp_hold_valid", int'(resp_valid), 1);
            chk("bp_no_ready", int'(acc0 | acc1), 0);
        end
        step(1, 0, 4'd0, 1, 4'd9, 1);
        chk("bp_hs", int'(hs), 1);
        chk("bp_no_accept_on_hs", int'(acc1), 0);
        step(1, 0, 4'd0, 1, 4'd9, 1);
        chk("bp_accept_after", int'(acc1), 1);
        step(1, 0, 4'd0, 0, 4'd0, 1);
        step(1, 0, 4'd0, 0, 4'd0, 1);

        // full sweep on requester 1
        do_reset();
        for (int k = 0; k < 16; k++) begin
            acc1 = 0;
            for (int t = 0; t < 6 && !acc1; t++) step(1, 0, 4'd0, 1, 4'(k), 1);
            chk("sweep_accept", int'(acc1), 1);
            hs = 0;
            for (int t = 0; t < 6 && !hs; t++) step(1, 0, 4'd0, 0, 4'd0, 1);
            chk("sweep_hs", int'(hs), 1);
            chk("sweep_val", hs_val, ref_tab[k]);
            chk("sweep_id", hs_id, 1);
        end
        chk("sweep_cnt1", int'(cnt1), 16);

        // reset during mapping of code 7
        step(1, 1, 4'd7, 0, 4'd0, 1);
        chk("mid_accept", int'(acc0), 1);
        step(0, 0, 4'd0, 0, 4'd0, 1);
        chk("mid_resp_valid", int'(resp_valid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_cnt1", int'(cnt1), 0);
        step(1, 0, 4'd0, 0, 4'd0, 1);
        step(1, 0, 4'd0, 0, 4'd0, 1);
        chk("mid_no_resp", int'(resp_valid), 0);
        step(1, 1, 4'd1, 1, 4'd2, 1);
        chk("mid_tie_req0", int'(acc0), 1);
        step(1, 0, 4'd0, 0, 4'd0, 1);
        step(1, 0, 4'd0, 0, 4'd0, 1);

        // counter wrap
        do_reset();
        for (int n = 0; n < 257; n++) begin
            step(1, 1, 4'(n), 0, 4'd0, 1);
            step(1, 0, 4'd0, 0, 4'd0, 1);
            step(1, 0, 4'd0, 0, 4'd0, 1);
        end
        chk("wrap_cnt0", int'(cnt0), 1);
        chk("wrap_cnt1", int'(cnt1), 0);

        // random traffic honouring code stability while waiting
        do_reset();
        v0 = 0; v1 = 0; c0 = 0; c1 = 0; acc0 = 0; acc1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(v0 && !acc0)) begin v0 = ($urandom_range(0, 2) != 0); c0 = 4'($urandom); end
            if (!(v1 && !acc1)) begin v1 = ($urandom_range(0, 2) != 0); c1 = 4'($urandom); end
            step(($urandom_range(0, 199) != 0), v0, c0, v1, c1, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
